// File: rtl/redundancy_pkg.sv
// Purpose: shared FSM encoding, default sizes and counter-width helper for the redundancy pair finder.
// Latency: none; declarations only.
// Backpressure: not applicable.
package redundancy_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;
    localparam int DEFAULT_MAX_LEN    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_EMIT,
        ST_FIN
    } state_t;

    // Index counter width; a one-entry buffer still needs a 1-bit counter.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/weight_row_buffer.sv
// Purpose: MAX_LEN x WORD_WIDTH register file holding one lowered filter row.
// Latency: write lands on the next clk edge; both read ports are combinational.
// Backpressure: none; the owner decides when to write.
module weight_row_buffer #(
    parameter int WORD_WIDTH = 8,
    parameter int MAX_LEN    = 32,
    parameter int AW         = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr_a,
    output logic [WORD_WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]         rd_addr_b,
    output logic [WORD_WIDTH-1:0] rd_data_b
);

    logic [WORD_WIDTH-1:0] mem [MAX_LEN];

    // Storage carries no reset: control logic never reads an entry before writing it in a job.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/redundancy_pair_finder.sv
// Purpose: buffers one weight row and emits (nearest earlier equal index, index) pairs; option REDUNDANCY_SKIP_ZERO_EN skips zero weights.
// Latency: len load cycles, then one comparison per cycle; a match shows pair_valid the next cycle.
// Backpressure: in_ready only in LOAD; EMIT holds idx1/idx2 stable until pair_ready.
module redundancy_pair_finder
    import redundancy_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int MAX_LEN    = DEFAULT_MAX_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic [WORD_WIDTH-1:0] idx1,
    output logic [WORD_WIDTH-1:0] idx2,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = cnt_width(MAX_LEN);

    state_t                state, state_nxt;
    logic [CW-1:0]         last_q, last_nxt;      // len - 1 of the current job
    logic [CW-1:0]         wr_ptr_q, wr_ptr_nxt;
    logic [CW-1:0]         i_q, i_nxt;            // candidate earlier index
    logic [CW-1:0]         j_q, j_nxt;            // index being resolved
    logic [WORD_WIDTH-1:0] idx1_q, idx1_nxt;
    logic [WORD_WIDTH-1:0] idx2_q, idx2_nxt;
    logic [CW-1:0]         len_m1;
    logic [WORD_WIDTH-1:0] rd_i, rd_j;
    logic                  wr_en;
    logic                  match;
    logic                  skip_j;
    logic                  advance_j;

    weight_row_buffer #(
        .WORD_WIDTH (WORD_WIDTH),
        .MAX_LEN    (MAX_LEN),
        .AW         (CW)
    ) u_buf (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_ptr_q),
        .wr_data   (in_data),
        .rd_addr_a (i_q),
        .rd_data_a (rd_i),
        .rd_addr_b (j_q),
        .rd_data_b (rd_j)
    );

    // Clamp the requested length to the buffer depth and keep it as len-1 so MAX_LEN itself fits in CW bits.
    always_comb begin
        if (32'(cfg_len) > MAX_LEN) begin
            len_m1 = CW'(MAX_LEN - 1);
        end else begin
            len_m1 = CW'(cfg_len - 1'b1);
        end
    end

    assign match = (rd_i == rd_j);

`ifdef REDUNDANCY_SKIP_ZERO_EN
    // Zero weights are pruned elsewhere, so a zero j is resolved in one cycle with no pair.
    assign skip_j = (rd_j == '0);
`else
    assign skip_j = 1'b0;
`endif

    // Next-state, counter updates and handshake outputs.
    always_comb begin
        state_nxt  = state;
        last_nxt   = last_q;
        wr_ptr_nxt = wr_ptr_q;
        i_nxt      = i_q;
        j_nxt      = j_q;
        idx1_nxt   = idx1_q;
        idx2_nxt   = idx2_q;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        pair_valid = 1'b0;
        done       = 1'b0;
        advance_j  = 1'b0;
        busy       = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    last_nxt   = len_m1;
                    wr_ptr_nxt = '0;
                    state_nxt  = (cfg_len == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == last_q) begin
                        if (last_q == '0) begin
                            state_nxt = ST_FIN;
                        end else begin
                            state_nxt = ST_SCAN;
                            j_nxt     = CW'(1);
                            i_nxt     = '0;
                        end
                    end
                end
            end
            ST_SCAN: begin
                // i walks down from j-1, so the first hit is the nearest predecessor.
                if (skip_j) begin
                    advance_j = 1'b1;
                end else if (match) begin
                    idx1_nxt  = WORD_WIDTH'(i_q);
                    idx2_nxt  = WORD_WIDTH'(j_q);
                    state_nxt = ST_EMIT;
                end else if (i_q == '0) begin
                    advance_j = 1'b1;
                end else begin
                    i_nxt = i_q - 1'b1;
                end
            end
            ST_EMIT: begin
                pair_valid = 1'b1;
                if (pair_ready) begin
                    advance_j = 1'b1;
                end
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Move on to the next j, or finish after the last one.
        if (advance_j) begin
            if (j_q == last_q) begin
                state_nxt = ST_FIN;
            end else begin
                j_nxt     = j_q + 1'b1;
                i_nxt     = j_q;
                state_nxt = ST_SCAN;
            end
        end
    end

    // State and counter registers with synchronous reset; reset drops any pending pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            last_q   <= '0;
            wr_ptr_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            idx1_q   <= '0;
            idx2_q   <= '0;
        end else begin
            state    <= state_nxt;
            last_q   <= last_nxt;
            wr_ptr_q <= wr_ptr_nxt;
            i_q      <= i_nxt;
            j_q      <= j_nxt;
            idx1_q   <= idx1_nxt;
            idx2_q   <= idx2_nxt;
        end
    end

    assign idx1 = idx1_q;
    assign idx2 = idx2_q;

endmodule

// File: tb/tb_redundancy_pair_finder.sv
// Purpose: self-checking bench for redundancy_pair_finder (table vectors, corner sequences, random jobs vs model).
// Latency: checks load latency, scan-to-done latency and pair hold under backpressure.
// Backpressure: drives pair_ready high, random, or held low for the first EMIT cycles.
module tb_redundancy_pair_finder;

    localparam int WW = 8;
    localparam int ML = 32;
`ifdef REDUNDANCY_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [WW-1:0] cfg_len;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_data;
    logic          pair_valid;
    logic          pair_ready;
    logic [WW-1:0] idx1;
    logic [WW-1:0] idx2;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    redundancy_pair_finder #(.WORD_WIDTH(WW), .MAX_LEN(ML)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_len    (cfg_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .idx1       (idx1),
        .idx2       (idx2),
        .busy       (busy),
        .done       (done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  w [0:63];
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    int          done_cnt;
    int          hs_cnt;
    int          last_hs_cyc;
    int          done_cyc;

    typedef struct packed {
        logic [7:0]       len;
        logic [1:0]       mode;
        logic [7:0][7:0]  w;
        logic [2:0]       np;
        logic [3:0][15:0] p;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0][7:0] pk_w(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7);
        logic [7:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
        r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
        return r;
    endfunction

    function automatic logic [15:0] pr(input int a, input int b);
        return {8'(a), 8'(b)};
    endfunction

    // Reference: remember the last position of each value; a revisit pairs with it.
    task automatic build_model(input int len_cfg);
        int len;
        int last_pos [256];
        int val;
        len = imin(len_cfg, ML);
        exp_q.delete();
        for (int v = 0; v < 256; v++) last_pos[v] = -1;
        for (int k = 0; k < len; k++) begin
            val = int'(w[k]);
            if (last_pos[val] >= 0 && !(SKIP_ZERO && val == 0))
                exp_q.push_back({8'(last_pos[val]), 8'(k)});
            last_pos[val] = k;
        end
    endtask

    // mode 0: pair_ready high; 1: random ready/valid/start; 2: ready low for first 5 EMIT cycles.
    task automatic run_job(input int len_cfg, input int n_offer, input int mode, input int budget);
        int k;
        int cyc;
        int pv_cnt;
        bit hold;
        logic [15:0] held;
        got.delete();
        done_cnt = 0; hs_cnt = 0; last_hs_cyc = -1; done_cyc = -1;
        k = 0; cyc = 0; pv_cnt = 0; hold = 1'b0; held = '0;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_len = 8'(len_cfg);
        @(negedge clk);
        check("busy_before_start", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        while (done_cnt == 0 && cyc < budget) begin
            in_valid = (k < n_offer) && (mode != 1 || $urandom_range(3) != 0);
            in_data  = (k < 64) ? w[k] : 8'h00;
            case (mode)
                0:       pair_ready = 1'b1;
                1:       pair_ready = 1'($urandom_range(1));
                default: pair_ready = (pv_cnt >= 5);
            endcase
            if (mode == 1) begin
                start   = 1'($urandom_range(1));
                cfg_len = 8'($urandom);
            end
            @(negedge clk);
            if (cyc == 0) check("busy_after_start", 32'(busy), 32'd1);
            if (hold) check("pair_hold", 32'({pair_valid, idx1, idx2}), 32'({1'b1, held}));
            hold = 1'b0;
            if (in_valid && in_ready) begin
                k++; hs_cnt++; last_hs_cyc = cyc;
            end
            if (pair_valid) begin
                pv_cnt++;
                if (pair_ready) got.push_back({idx1, idx2});
                else begin
                    hold = 1'b1;
                    held = {idx1, idx2};
                end
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        start = 1'b0; in_valid = 1'b0; pair_ready = 1'b1;
        // Watch a few idle cycles for stray pairs or pulses.
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (pair_valid) got.push_back({idx1, idx2});
            @(posedge clk); #1;
        end
    endtask

    task automatic compare_pairs(input string tag);
        check({tag, "_npairs"}, 32'(got.size()), 32'(exp_q.size()));
        for (int p = 0; p < exp_q.size() && p < got.size(); p++)
            check({tag, "_pair"}, 32'(got[p]), 32'(exp_q[p]));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int k;
        int cyc;
        int len;
        int stray_done;
        bit seen;

        reset = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_data = '0; pair_ready = 1'b0;
        for (int m = 0; m < 64; m++) w[m] = '0;

        vecs[0] = '0; vecs[0].len = 4; vecs[0].mode = 0;
        vecs[0].w = pk_w(5, 3, 5, 5, 0, 0, 0, 0);
        vecs[0].np = 2; vecs[0].p[0] = pr(0, 2); vecs[0].p[1] = pr(2, 3);
        vecs[1] = '0; vecs[1].len = 6; vecs[1].mode = 0;
        vecs[1].w = pk_w(1, 2, 3, 4, 5, 6, 0, 0);
        vecs[1].np = 0;
        vecs[2] = '0; vecs[2].len = 3; vecs[2].mode = 2;
        vecs[2].w = pk_w(7, 7, 7, 0, 0, 0, 0, 0);
        vecs[2].np = 2; vecs[2].p[0] = pr(0, 1); vecs[2].p[1] = pr(1, 2);
        vecs[3] = '0; vecs[3].len = 0; vecs[3].mode = 0; vecs[3].np = 0;
        vecs[4] = '0; vecs[4].len = 1; vecs[4].mode = 0;
        vecs[4].w = pk_w(9, 0, 0, 0, 0, 0, 0, 0); vecs[4].np = 0;
        vecs[5] = '0; vecs[5].len = 4; vecs[5].mode = 0;
        vecs[5].w = pk_w(0, 0, 4, 4, 0, 0, 0, 0);
`ifdef REDUNDANCY_SKIP_ZERO_EN
        vecs[5].np = 1; vecs[5].p[0] = pr(2, 3);
`else
        vecs[5].np = 2; vecs[5].p[0] = pr(0, 1); vecs[5].p[1] = pr(2, 3);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_pair_valid", 32'(pair_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'({idx1, idx2}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table-driven directed vectors.
        for (int t = 0; t < NV; t++) begin
            for (int m = 0; m < 8; m++) w[m] = vecs[t].w[m];
            run_job(int'(vecs[t].len), int'(vecs[t].len), int'(vecs[t].mode), 200);
            exp_q.delete();
            for (int p = 0; p < int'(vecs[t].np); p++) exp_q.push_back(vecs[t].p[p]);
            compare_pairs($sformatf("vec%0d", t));
            check($sformatf("vec%0d_loads", t), 32'(hs_cnt), 32'(vecs[t].len));
            if (t == 1) check("distinct_done_latency", 32'(done_cyc - last_hs_cyc), 32'd16);
        end

        // Oversized job: only MAX_LEN words are taken even while more are offered.
        for (int m = 0; m < 40; m++) w[m] = 8'($urandom_range(7));
        run_job(40, 40, 0, 2000);
        build_model(40);
        compare_pairs("clamp");
        check("clamp_loads", 32'(hs_cnt), 32'(ML));

        // Reset while a pair is pending.
        for (int m = 0; m < 3; m++) w[m] = 8'd7;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0; pair_ready = 1'b0; in_valid = 1'b1;
        k = 0; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 50) begin
            in_data = w[(k < 3) ? k : 0];
            @(negedge clk);
            if (in_valid && in_ready) k++;
            if (pair_valid) seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (k >= 3) in_valid = 1'b0;
        end
        check("rst_reach_emit", 32'(seen), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_pair_valid", 32'(pair_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        stray_done = int'(done);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            stray_done += int'(done);
            @(posedge clk); #1;
        end
        check("midrst_no_done", 32'(stray_done), 32'd0);
        w[0] = 8'd5; w[1] = 8'd3; w[2] = 8'd5; w[3] = 8'd5;
        run_job(4, 4, 0, 200);
        build_model(4);
        compare_pairs("after_rst");

        // Random jobs with random handshakes against the model.
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(34);
            for (int m = 0; m < 64; m++)
                w[m] = (r % 2 == 0) ? 8'($urandom_range(3)) : 8'($urandom_range(15));
            run_job(len, len + $urandom_range(3), 1, 3000);
            build_model(len);
            compare_pairs($sformatf("rand%0d", r));
            check($sformatf("rand%0d_loads", r), 32'(hs_cnt), 32'(imin(len, ML)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
